data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving load/store requests from the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. Holds a word-organised storage array, inserts a configurable number of wait states per access, applies byte-lane write strobes, and flags misaligned or out-of-range accesses with an error response. It is the target side of the core's data-memory interface and replaces the single-cycle data memory once the MEM stage gains stall support.

---
 rtl/data_mem_responder.sv | 129 ++++++++++++
 tb/tb_data_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target: word array with byte strobes, programmable wait
// states, alignment/range error responses, one outstanding request at a time.
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [1:0]  dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // request side is only ready in IDLE, the response side only valid in RESP.
   localparam int AW   = $clog2(DEPTH);
   localparam bit LAT0 = (LATENCY == 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_rsp_valid;
   logic [31:0] r_mem [DEPTH];

   logic          w_accept;
   logic          w_do_access;
   logic          w_a_write;
   logic [31:0]   w_a_addr;
   logic [31:0]   w_a_wdata;
   logic [3:0]    w_a_wstrb;
   logic [AW-1:0] w_idx;
   logic          w_err;

   assign w_accept    = (r_state == S_IDLE) && req_valid;
   assign w_do_access = (w_accept && LAT0) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

   // With no wait states the access uses the live request, otherwise the captured copy.
   assign w_a_write = (r_state == S_IDLE) ? req_write : r_write;
   assign w_a_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_a_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
   assign w_a_wstrb = (r_state == S_IDLE) ? req_wstrb : r_wstrb;
   assign w_idx     = w_a_addr[AW+1:2];
   assign w_err     = (|w_a_addr[1:0]) || (|w_a_addr[31:AW+2]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = LAT0 ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      dbg_state = r_state;
      rsp_valid = r_rsp_valid;
      rsp_rdata = r_rdata;
      rsp_err   = r_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_wstrb <= 4'd0;
      end else if (w_accept) begin
         r_cnt   <= LAT0 ? 4'd0 : 4'(LATENCY - 1);
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wstrb <= req_wstrb;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp_valid <= 1'b0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
      end else if (w_do_access) begin
         r_rsp_valid <= 1'b1;
         r_err       <= w_err;
         r_rdata     <= (w_err || w_a_write) ? 32'd0 : r_mem[w_idx];
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Storage is not reset; rst gates the write so nothing lands while reset is held.
   always_ff @(posedge clk) begin
      if (rst && w_do_access && w_a_write && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_a_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: cycle-numbered reference model, per-cycle compare,
// directed literal checks, randomized traffic, and a zero-latency instance.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        z_req_valid = 1'b0;
  logic        z_req_write = 1'b0;
  logic [31:0] z_req_addr = 32'd0;
  logic [31:0] z_req_wdata = 32'd0;
  logic [3:0]  z_req_wstrb = 4'd0;
  logic        z_rsp_ready = 1'b1;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;
  logic [1:0]  z_dbg_state;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit rdy_mode = 1'b0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .req_wstrb(z_req_wstrb), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy), .dbg_state(z_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A request accepted at edge number T completes its access at edge T+LAT and its
  // response is visible from then until an edge where rsp_ready is high.
  int          cyc = 0;
  int          m_T = 0;
  int          m_acc_cnt = 0;
  bit          m_pend = 1'b0;
  logic        m_w = 1'b0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_d = 32'd0;
  logic [3:0]  m_s = 4'd0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  logic [31:0] m_mem [DEPTH];

  task automatic m_access();
    logic [31:0] idx;
    idx = m_a >> 2;
    m_err = (m_a % 4 != 0) || (idx >= 32'(DEPTH));
    m_rdata = (m_err || m_w) ? 32'd0 : m_mem[int'(idx)];
    if (!m_err && m_w) begin
      for (int b = 0; b < 4; b++)
        if (m_s[b]) m_mem[int'(idx)][8*b +: 8] = m_d[8*b +: 8];
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (!m_pend) begin
        if (req_valid) begin
          m_pend = 1'b1;
          m_T = cyc;
          m_acc_cnt++;
          m_w = req_write; m_a = req_addr; m_d = req_wdata; m_s = req_wstrb;
          if (LAT == 0) m_access();
        end
      end else if ((cyc - 1 >= m_T + LAT) && rsp_ready) begin
        m_pend = 1'b0;
      end else if (cyc == m_T + LAT) begin
        m_access();
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      bit ev;
      ev = m_pend && (cyc >= m_T + LAT);
      chk("cyc_req_ready", req_ready, !m_pend);
      chk("cyc_busy", busy, m_pend);
      chk("cyc_rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("cyc_rsp_rdata", rsp_rdata, m_rdata);
        chk("cyc_rsp_err", rsp_err, m_err);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_junk();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_rdy();
    if (rdy_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic re,
                        output int lat);
    int c0, n;
    bit seen;
    rd = 32'd0; re = 1'b0; lat = 0; seen = 1'b0;
    @(negedge clk);
    c0 = m_acc_cnt;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    do begin @(negedge clk); n++; rand_rdy(); end while (m_acc_cnt == c0 && n < 100);
    lat = 1;
    while (!rsp_valid && n < 200) begin
      drive_junk(); @(negedge clk); lat++; n++; rand_rdy();
    end
    if (rsp_valid) begin seen = 1'b1; rd = rsp_rdata; re = rsp_err; end
    chk("rsp_seen", seen, 1'b1);
    while (m_pend && n < 400) begin
      drive_junk(); @(negedge clk); n++; rand_rdy();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (m_pend && n < 100) begin @(negedge clk); n++; end
    req_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd, a;
    logic re;
    int lat, c0, n, sel;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, rd, re, lat);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, re, lat);
    chk("st10_lat", lat, 3); chk("st10_err", re, 1'b0); chk("st10_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, re, lat);
    chk("ld10_lat", lat, 3); chk("ld10_err", re, 1'b0); chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("model_ld10", m_rdata, 32'hDEADBEEF);

    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, re, lat);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, re, lat);
    do_req(1'b0, 32'h20, 32'd0, 4'h0, rd, re, lat);
    chk("strb_rdata", rd, 32'h11BB33DD);
    chk("model_strb", m_rdata, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, re, lat);
    do_req(1'b0, 32'h20, 32'd0, 4'h0, rd, re, lat);
    chk("strb0_rdata", rd, 32'h11BB33DD);

    do_req(1'b0, 32'h13, 32'd0, 4'h0, rd, re, lat);
    chk("mis_err", re, 1'b1); chk("mis_rdata", rd, 32'd0);
    do_req(1'b1, 32'h0, 32'h01234567, 4'hF, rd, re, lat);
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, re, lat);
    chk("oor_err", re, 1'b1); chk("model_oor", m_err, 1'b1);
    do_req(1'b0, 32'h0, 32'd0, 4'h0, rd, re, lat);
    chk("w0_unchanged", rd, 32'h01234567); chk("w0_err", re, 1'b0);

    // backpressure with a second request waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    c0 = m_acc_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'd0; req_wstrb = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (m_acc_cnt == c0 && n < 50);
    req_write = 1'b1; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_err", rsp_err, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_ready", req_ready, 1'b1);
    chk("bp_after_hs_valid", rsp_valid, 1'b0);
    @(negedge clk);
    chk("bp_second_busy", busy, 1'b1);
    req_valid = 1'b0;
    wait_idle();
    do_req(1'b0, 32'h10, 32'd0, 4'h0, rd, re, lat);
    chk("bp_second_store", rd, 32'h0BADF00D);

    // reset while waiting
    do_req(1'b1, 32'h8, 32'h600DCAFE, 4'hF, rd, re, lat);
    @(negedge clk);
    c0 = m_acc_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (m_acc_cnt == c0 && n < 50);
    req_valid = 1'b0;
    chk("wait_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_req_ready", req_ready, 1'b1);
    chk("mrst_rsp_valid", rsp_valid, 1'b0);
    chk("mrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mrst_rsp_err", rsp_err, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 32'h8, 32'd0, 4'h0, rd, re, lat);
    chk("mrst_w2_kept", rd, 32'h600DCAFE);

    // randomized traffic with random backpressure
    rdy_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15) * 4);
      if (sel == 8) a = a + 32'($urandom_range(1, 3));
      else if (sel == 9) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, re, lat);
    end
    rdy_mode = 1'b0;
    wait_idle();
    chk_en = 1'b0;

    // zero-latency instance, back-to-back traffic
    @(negedge clk);
    z_rsp_ready = 1'b1;
    chk("z_idle_ready", z_req_ready, 1'b1);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h4;
    z_req_wdata = 32'h5A5A0F0F; z_req_wstrb = 4'hF;
    @(negedge clk);
    chk("z_st_valid", z_rsp_valid, 1'b1);
    chk("z_st_ready", z_req_ready, 1'b0);
    chk("z_st_err", z_rsp_err, 1'b0);
    z_req_write = 1'b0;
    @(negedge clk);
    chk("z_hs_valid", z_rsp_valid, 1'b0);
    chk("z_hs_ready", z_req_ready, 1'b1);
    @(negedge clk);
    chk("z_ld1_valid", z_rsp_valid, 1'b1);
    chk("z_ld1_rdata", z_rsp_rdata, 32'h5A5A0F0F);
    chk("z_ld1_busy", z_busy, 1'b1);
    @(negedge clk);
    chk("z_gap_ready", z_req_ready, 1'b1);
    chk("z_gap_valid", z_rsp_valid, 1'b0);
    @(negedge clk);
    chk("z_ld2_valid", z_rsp_valid, 1'b1);
    chk("z_ld2_rdata", z_rsp_rdata, 32'h5A5A0F0F);
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_end_busy", z_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
